// File: rtl/wrr_arbiter_pkg.sv
// Shared types and defaults for the weighted round-robin memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wrr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int DEF_REQ_WIDTH = 10;
    localparam int DEF_CREDIT_W  = 3;

endpackage

// File: rtl/wrr_arbiter_rr_pick.sv
// Round-robin priority pick: lowest set request at or above ptr, else lowest set overall.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick #(
    parameter int N  = 10,
    parameter int PW = 4
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt_oh,
    output logic          vld
);

    logic [N-1:0] mask;
    logic [N-1:0] masked;
    logic [N-1:0] src;

    // Thermometer mask from ptr upward, then isolate the lowest set bit (x & -x).
    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (PW'(i) >= ptr);
        end
        masked = req & mask;
        src    = (|masked) ? masked : req;
        gnt_oh = src & (~src + N'(1));
        vld    = |req;
    end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter for a shared memory port with burst lock.
// Latency: grant registered, 1 cycle after request; re-arbitration on release has no bubble.
// Backpressure: mem_ready=0 freezes grant, credit and pointer; only an owner dropping req releases.
module wrr_arbiter
    import wrr_arbiter_pkg::*;
#(
    parameter int REQ_WIDTH = DEF_REQ_WIDTH,
    parameter int CREDIT_W  = DEF_CREDIT_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [REQ_WIDTH-1:0]            req,
    input  logic [REQ_WIDTH*CREDIT_W-1:0]   weight,
    input  logic                            lock,
    input  logic                            mem_ready,
    output logic [REQ_WIDTH-1:0]            gnt,
    output logic                            gnt_valid,
    output logic [$clog2(REQ_WIDTH)-1:0]    gnt_id
);

    localparam int IDW = $clog2(REQ_WIDTH);

    state_t                state_q, state_d;
    logic [REQ_WIDTH-1:0]  gnt_q, gnt_d;
    logic [IDW-1:0]        id_q, id_d;
    logic [IDW-1:0]        ptr_q, ptr_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;

    logic [IDW-1:0]        owner_nxt;
    logic [IDW-1:0]        pick_ptr;
    logic [REQ_WIDTH-1:0]  pick_oh;
    logic                  pick_vld;
    logic [IDW-1:0]        pick_id;
    logic [CREDIT_W-1:0]   pick_credit;
    logic                  owner_req;

    // During a grant the pick already uses the post-release pointer so a release
    // hands over in the same cycle; in IDLE the stored pointer is used.
    always_comb begin
        owner_nxt = (id_q == IDW'(REQ_WIDTH - 1)) ? '0 : id_q + IDW'(1);
        pick_ptr  = (state_q == GRANT) ? owner_nxt : ptr_q;
        owner_req = |(req & gnt_q);
    end

    rr_pick #(
        .N  (REQ_WIDTH),
        .PW (IDW)
    ) u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .gnt_oh (pick_oh),
        .vld    (pick_vld)
    );

    // Encode the pick and fetch its weight; a zero weight still buys one transfer.
    always_comb begin
        pick_id     = '0;
        pick_credit = '0;
        for (int i = 0; i < REQ_WIDTH; i++) begin
            if (pick_oh[i]) begin
                pick_id     = IDW'(i);
                pick_credit = weight[i*CREDIT_W +: CREDIT_W];
            end
        end
        if (pick_credit == '0) begin
            pick_credit = CREDIT_W'(1);
        end
    end

    // Next-state, credit and pointer decisions.
    always_comb begin
        logic do_arb;
        state_d  = state_q;
        gnt_d    = gnt_q;
        id_d     = id_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        do_arb   = 1'b0;

        case (state_q)
            IDLE: begin
                do_arb = pick_vld;
            end
            GRANT: begin
                if (!owner_req) begin
                    // Owner gave up (even while stalled): release without a transfer.
                    ptr_d  = owner_nxt;
                    do_arb = 1'b1;
                end else if (mem_ready) begin
                    if (lock) begin
                        credit_d = (credit_q > CREDIT_W'(1)) ? credit_q - CREDIT_W'(1) : CREDIT_W'(1);
                    end else if (credit_q > CREDIT_W'(1)) begin
                        credit_d = credit_q - CREDIT_W'(1);
                    end else begin
                        ptr_d  = owner_nxt;
                        do_arb = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_arb) begin
            if (pick_vld) begin
                state_d  = GRANT;
                gnt_d    = pick_oh;
                id_d     = pick_id;
                credit_d = pick_credit;
            end else begin
                state_d  = IDLE;
                gnt_d    = '0;
                id_d     = '0;
                credit_d = '0;
            end
        end
    end

    // State and registered outputs; reset abandons any burst and restarts at requester 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            id_q     <= '0;
            ptr_q    <= '0;
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            id_q     <= id_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_id    = id_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
module tb_wrr_arbiter;

    localparam int N   = 10;
    localparam int CW  = 3;
    localparam int IDW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*CW-1:0] weight = '0;
    logic            lock = 1'b0;
    logic            mem_ready = 1'b0;
    logic [N-1:0]    gnt;
    logic            gnt_valid;
    logic [IDW-1:0]  gnt_id;

    int errors = 0;
    int checks = 0;

    wrr_arbiter #(.REQ_WIDTH(N), .CREDIT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .weight    (weight),
        .lock      (lock),
        .mem_ready (mem_ready),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all_weights(input int w);
        for (int i = 0; i < N; i++) weight[i*CW +: CW] = CW'(w);
    endtask

    task automatic set_weight(input int idx, input int w);
        weight[idx*CW +: CW] = CW'(w);
    endtask

    task automatic do_reset();
        rst = 1'b0; req = '0; lock = 1'b0; mem_ready = 1'b0;
        step();
        rst = 1'b1;
    endtask

    function automatic logic [IDW-1:0] id_of(input logic [N-1:0] oh);
        id_of = '0;
        for (int i = 0; i < N; i++) if (oh[i]) id_of = IDW'(i);
    endfunction

    task automatic test_reset();
        rst = 1'b0; req = 10'h3FF; mem_ready = 1'b1;
        step(); step();
        checks++; if (gnt !== 10'h000) begin errors++; $display("FAIL reset_gnt: got %h expected 000", gnt); end
        checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", gnt_valid); end
        checks++; if (gnt_id !== 4'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", gnt_id); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp [4] = '{10'h001, 10'h004, 10'h008, 10'h001};
        set_all_weights(1); req = 10'b0000001101; mem_ready = 1'b1; lock = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (gnt !== exp[i]) begin errors++; $display("FAIL rr_gnt[%0d]: got %h expected %h", i, gnt, exp[i]); end
            checks++; if (gnt_id !== id_of(exp[i])) begin errors++; $display("FAIL rr_id[%0d]: got %0d expected %0d", i, gnt_id, id_of(exp[i])); end
        end
    endtask

    task automatic test_weighted();
        logic [N-1:0] exp [7] = '{10'h001, 10'h001, 10'h001, 10'h004, 10'h001, 10'h001, 10'h001};
        do_reset();
        set_all_weights(1); set_weight(0, 3);
        req = 10'b0000000101; mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            checks++; if (gnt !== exp[i]) begin errors++; $display("FAIL weighted_gnt[%0d]: got %h expected %h", i, gnt, exp[i]); end
        end
    endtask

    task automatic test_lock();
        do_reset();
        set_all_weights(1); req = 10'h00C; lock = 1'b1; mem_ready = 1'b1;
        step();
        checks++; if (gnt !== 10'h004) begin errors++; $display("FAIL lock_first: got %h expected 004", gnt); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (gnt !== 10'h004) begin errors++; $display("FAIL lock_hold[%0d]: got %h expected 004", i, gnt); end
        end
        lock = 1'b0;
        step();
        checks++; if (gnt !== 10'h008) begin errors++; $display("FAIL lock_release: got %h expected 008", gnt); end
    endtask

    task automatic test_wrap();
        do_reset();
        set_all_weights(1); req = 10'h200; mem_ready = 1'b1;
        step();
        checks++; if (gnt_id !== 4'd9) begin errors++; $display("FAIL wrap_owner: got %0d expected 9", gnt_id); end
        req = 10'b1000000011;
        step();
        checks++; if (gnt !== 10'h001) begin errors++; $display("FAIL wrap_first: got %h expected 001", gnt); end
        step();
        checks++; if (gnt !== 10'h002) begin errors++; $display("FAIL wrap_second: got %h expected 002", gnt); end
    endtask

    task automatic test_stall();
        do_reset();
        set_all_weights(1); set_weight(1, 2);
        req = 10'h006; mem_ready = 1'b0;
        step();
        checks++; if (gnt !== 10'h002) begin errors++; $display("FAIL stall_first: got %h expected 002", gnt); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (gnt !== 10'h002) begin errors++; $display("FAIL stall_hold[%0d]: got %h expected 002", i, gnt); end
        end
        // Credit 2 must have survived the stall: two transfers before handing over.
        mem_ready = 1'b1;
        step();
        checks++; if (gnt !== 10'h002) begin errors++; $display("FAIL stall_credit: got %h expected 002", gnt); end
        step();
        checks++; if (gnt !== 10'h004) begin errors++; $display("FAIL stall_handover: got %h expected 004", gnt); end
        // Owner 2 drops while stalled: pointer moves to 3 and wraps to requester 1.
        mem_ready = 1'b0; req = 10'h002;
        step();
        checks++; if (gnt !== 10'h002) begin errors++; $display("FAIL stall_drop_next: got %h expected 002", gnt); end
        req = 10'h000;
        step();
        checks++; if (gnt !== 10'h000) begin errors++; $display("FAIL stall_drop_idle: got %h expected 000", gnt); end
        checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL stall_idle_valid: got %b expected 0", gnt_valid); end
        checks++; if (gnt_id !== 4'd0) begin errors++; $display("FAIL stall_idle_id: got %0d expected 0", gnt_id); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        set_all_weights(1); set_weight(3, 3);
        req = 10'h008; mem_ready = 1'b1;
        step(); step();
        checks++; if (gnt !== 10'h008) begin errors++; $display("FAIL midrst_owner: got %h expected 008", gnt); end
        #2 rst = 1'b0;
        #1;
        checks++; if (gnt !== 10'h000) begin errors++; $display("FAIL midrst_async_gnt: got %h expected 000", gnt); end
        checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL midrst_async_valid: got %b expected 0", gnt_valid); end
        req = 10'h3FF;
        step();
        rst = 1'b1;
        step();
        checks++; if (gnt !== 10'h001) begin errors++; $display("FAIL midrst_restart: got %h expected 001", gnt); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] exp [4] = '{10'h001, 10'h002, 10'h001, 10'h002};
        do_reset();
        set_all_weights(1); set_weight(4, 2);
        req = 10'h010; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (gnt !== 10'h010) begin errors++; $display("FAIL solo_regrant[%0d]: got %h expected 010", i, gnt); end
        end
        do_reset();
        set_all_weights(1); set_weight(0, 0);
        req = 10'h003; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (gnt !== exp[i]) begin errors++; $display("FAIL zero_weight[%0d]: got %h expected %h", i, gnt, exp[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_weighted();
        test_lock();
        test_wrap();
        test_stall();
        test_reset_mid_burst();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
